pio8_edge_irq: RTL and testbench

PIO8_EDGE_IRQ -- requirements
Module: pio8_edge_irq

---
 rtl/pio8_pkg.sv | 25 ++
 rtl/pio8_edge_irq_if.sv | 24 ++
 rtl/pio_debounce.sv | 66 ++++++
 rtl/pio8_edge_irq.sv | 105 ++++++++++
 tb/tb_pio8_edge_irq.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pio8_pkg.sv
// Shared constants for the PIO8 edge-interrupt block: register word
// addresses, pin count, debounce-threshold reset value and a byte-lane
// update helper used by the register file.
package pio8_pkg;

   localparam int NPIN = 8;

   localparam logic [4:0] ADDR_NPIN   = 5'd0;
   localparam logic [4:0] ADDR_ID     = 5'd1;
   localparam logic [4:0] ADDR_STABLE = 5'd2;
   localparam logic [4:0] ADDR_EDGE   = 5'd3;
   localparam logic [4:0] ADDR_MASK   = 5'd4;
   localparam logic [4:0] ADDR_EN     = 5'd5;
   localparam logic [4:0] ADDR_DBTH   = 5'd6;

   localparam logic [7:0] DBTH_RST = 8'd4;

   // Byte-lane gated register update.
   function automatic logic [7:0] lane_upd(input logic [7:0] old_v,
                                           input logic [7:0] new_v,
                                           input logic       en);
      return en ? new_v : old_v;
   endfunction

endpackage

// File: rtl/pio8_edge_irq_if.sv
// Avalon-MM slave bus of the PIO8 edge-interrupt block.
//   slave  : the register file (drives readdata / waitrequest)
//   master : the bus host (drives address, strobes, write data)
interface pio8_edge_irq_if;
   logic [31:0] avs_gpio_writedata;
   logic [31:0] avs_gpio_readdata;
   logic [4:0]  avs_gpio_address;
   logic [3:0]  avs_gpio_byteenable;
   logic        avs_gpio_write;
   logic        avs_gpio_read;
   logic        avs_gpio_waitrequest;

   modport slave (
      input  avs_gpio_writedata, avs_gpio_address, avs_gpio_byteenable,
             avs_gpio_write, avs_gpio_read,
      output avs_gpio_readdata, avs_gpio_waitrequest
   );

   modport master (
      output avs_gpio_writedata, avs_gpio_address, avs_gpio_byteenable,
             avs_gpio_write, avs_gpio_read,
      input  avs_gpio_readdata, avs_gpio_waitrequest
   );
endinterface

// File: rtl/pio_debounce.sv
// One-pin front end: 2-flop synchronizer, tick-driven debounce counter and
// the debounced level, with single-cycle rise/fall pulses.
//   clk, rst_n : clock, async active-low reset
//   pin_async  : raw pad level
//   tick       : shared prescaler pulse
//   db_thresh  : ticks of disagreement needed to commit; 0 = no debounce
//   stable     : debounced level
//   rise, fall : asserted in the cycle before stable changes, so the edge
//                register and stable update on the same clock edge
module pio_debounce
   import pio8_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pin_async,
   input  logic       tick,
   input  logic [7:0] db_thresh,
   output logic       stable,
   output logic       rise,
   output logic       fall
);

   logic [1:0] sync_q, sync_d;
   logic [7:0] cnt_q, cnt_d;
   logic       stable_q, stable_d;
   logic       sync;

   assign sync = sync_q[1];

   always_comb begin
      sync_d   = {sync_q[0], pin_async};
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (db_thresh == 8'd0) begin
         stable_d = sync;
         cnt_d    = '0;
      end else if (sync == stable_q) begin
         cnt_d = '0;
      end else if (tick) begin
         // ">=" so a threshold lowered mid-count commits on the next tick
         if (cnt_q >= db_thresh - 8'd1) begin
            stable_d = sync;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;
   assign rise   = stable_d & ~stable_q;
   assign fall   = ~stable_d & stable_q;

endmodule

// File: rtl/pio8_edge_irq.sv
// PIO8 edge-detect interrupt controller. Eight debounced inputs, per-pin
// rise/fall enables, sticky W1C edge register, mask, level interrupt.
//   csi_MCLK_clk      : clock
//   rsi_MRST_reset_n  : async active-low reset
//   avs               : Avalon-MM slave (1-cycle registered read, no wait)
//   coe_pin_in[7:0]   : raw pad levels
//   ins_IRQ_irq       : registered |(EDGE & MASK)
module pio8_edge_irq
   import pio8_pkg::*;
#(
   parameter int          DB_PRESCALE = 1000,
   parameter logic [31:0] ID_WORD     = 32'hEA680002
) (
   input  logic                  csi_MCLK_clk,
   input  logic                  rsi_MRST_reset_n,
   pio8_edge_irq_if.slave        avs,
   input  logic [NPIN-1:0]       coe_pin_in,
   output logic                  ins_IRQ_irq
);

   logic [15:0]     pre_q, pre_d;
   logic            tick;
   logic [NPIN-1:0] stable, rise, fall;
   logic [7:0]      edge_q, edge_d, mask_q, mask_d;
   logic [7:0]      rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   logic [7:0]      dbth_q, dbth_d, edge_clr;
   logic [31:0]     readdata_q, readdata_d;
   logic            irq_q, irq_d;
   logic            wr0, wr1;
   logic [4:0]      addr;
   logic [31:0]     wd;
   logic            unused_bits;

   assign addr = avs.avs_gpio_address;
   assign wd   = avs.avs_gpio_writedata;
   assign wr0  = avs.avs_gpio_write & avs.avs_gpio_byteenable[0];
   assign wr1  = avs.avs_gpio_write & avs.avs_gpio_byteenable[1];
   assign unused_bits = ^{wd[31:16], avs.avs_gpio_byteenable[3:2], avs.avs_gpio_read};

   // Free-running debounce prescaler
   assign tick  = (pre_q == 16'(DB_PRESCALE - 1));
   assign pre_d = tick ? 16'd0 : pre_q + 16'd1;

   for (genvar i = 0; i < NPIN; i++) begin : g_pin
      pio_debounce u_db (
         .clk       (csi_MCLK_clk),
         .rst_n     (rsi_MRST_reset_n),
         .pin_async (coe_pin_in[i]),
         .tick      (tick),
         .db_thresh (dbth_q),
         .stable    (stable[i]),
         .rise      (rise[i]),
         .fall      (fall[i])
      );
   end

   always_comb begin
      edge_clr  = (wr0 && addr == ADDR_EDGE) ? wd[7:0] : 8'd0;
      // Clear first, then set: a new edge beats a simultaneous W1C
      edge_d    = (edge_q & ~edge_clr) | (rise & rise_en_q) | (fall & fall_en_q);
      mask_d    = lane_upd(mask_q,    wd[7:0],  wr0 && addr == ADDR_MASK);
      rise_en_d = lane_upd(rise_en_q, wd[7:0],  wr0 && addr == ADDR_EN);
      fall_en_d = lane_upd(fall_en_q, wd[15:8], wr1 && addr == ADDR_EN);
      dbth_d    = lane_upd(dbth_q,    wd[7:0],  wr0 && addr == ADDR_DBTH);
      irq_d     = |(edge_q & mask_q);
      readdata_d = 32'd0;
      case (addr)
         ADDR_NPIN:   readdata_d = 32'(NPIN);
         ADDR_ID:     readdata_d = ID_WORD;
         ADDR_STABLE: readdata_d = {24'd0, stable};
         ADDR_EDGE:   readdata_d = {24'd0, edge_q};
         ADDR_MASK:   readdata_d = {24'd0, mask_q};
         ADDR_EN:     readdata_d = {16'd0, fall_en_q, rise_en_q};
         ADDR_DBTH:   readdata_d = {24'd0, dbth_q};
         default:     readdata_d = 32'd0;
      endcase
   end

   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         pre_q      <= '0;
         edge_q     <= '0;
         mask_q     <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '0;
         dbth_q     <= DBTH_RST;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         edge_q     <= edge_d;
         mask_q     <= mask_d;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         dbth_q     <= dbth_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign avs.avs_gpio_readdata    = readdata_q;
   assign avs.avs_gpio_waitrequest = 1'b0;
   assign ins_IRQ_irq              = irq_q;

endmodule

// File: tb/tb_pio8_edge_irq.sv
// Bench for pio8_edge_irq with DB_PRESCALE=4. Reads push their expected
// value to a queue; a monitor pops and compares the registered read data.
module tb_pio8_edge_irq;

   localparam logic [31:0] ID = 32'hEA680002;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pins = 8'd0;
   logic       irq;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pio8_edge_irq_if bus();

   pio8_edge_irq #(.DB_PRESCALE(4), .ID_WORD(ID)) dut (
      .csi_MCLK_clk     (clk),
      .rsi_MRST_reset_n (rst_n),
      .avs              (bus.slave),
      .coe_pin_in       (pins),
      .ins_IRQ_irq      (irq)
   );

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] exp;
   } rexp_t;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   rexp_t exp_q[$];
   vec_t  vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
      n_cmp++;
      if (v < lo || v > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d..%0d", nm, v, lo, hi);
      end
   endtask

   // Read-data monitor: data is valid one edge after read was sampled
   initial begin
      logic  seen;
      rexp_t e;
      forever begin
         @(posedge clk);
         seen = bus.avs_gpio_read;
         @(negedge clk);
         if (seen) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rd unexpected: got 0x%08h want none", bus.avs_gpio_readdata);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("rd addr %0d", e.addr), bus.avs_gpio_readdata, e.exp);
            end
         end
      end
   end

   task automatic rd(input logic [4:0] a, input logic [31:0] exp);
      bus.avs_gpio_address = a;
      bus.avs_gpio_read    = 1'b1;
      exp_q.push_back({a, exp});
      @(negedge clk);
      bus.avs_gpio_read = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.avs_gpio_address    = a;
      bus.avs_gpio_writedata  = d;
      bus.avs_gpio_byteenable = be;
      bus.avs_gpio_write      = 1'b1;
      @(negedge clk);
      bus.avs_gpio_write      = 1'b0;
      bus.avs_gpio_byteenable = 4'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_irq(input int start, input int bound, output int lat);
      lat = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (irq) begin
            lat = cyc - start;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      int lat, hi, rel;
      bit found;
      vecs[0]  = '{5'd5, 32'h0000_AB00, 4'b0001, 32'h0000_0000};
      vecs[1]  = '{5'd5, 32'h0000_3C5A, 4'b0011, 32'h0000_3C5A};
      vecs[2]  = '{5'd5, 32'h0000_FF00, 4'b0010, 32'h0000_FF5A};
      vecs[3]  = '{5'd5, 32'h0000_1100, 4'b0001, 32'h0000_FF00};
      vecs[4]  = '{5'd5, 32'h0000_0000, 4'b0011, 32'h0000_0000};
      vecs[5]  = '{5'd4, 32'h0000_00FF, 4'b0001, 32'h0000_00FF};
      vecs[6]  = '{5'd4, 32'h0000_0000, 4'b0000, 32'h0000_00FF};
      vecs[7]  = '{5'd4, 32'h1234_5600, 4'b1111, 32'h0000_0000};
      vecs[8]  = '{5'd6, 32'h0000_0007, 4'b0001, 32'h0000_0007};
      vecs[9]  = '{5'd6, 32'h0000_0099, 4'b1110, 32'h0000_0007};
      vecs[10] = '{5'd6, 32'h0000_0004, 4'b0001, 32'h0000_0004};
      vecs[11] = '{5'd0, 32'h0000_0055, 4'b1111, 32'h0000_0008};
      vecs[12] = '{5'd3, 32'h0000_00FF, 4'b0001, 32'h0000_0000};
      vecs[13] = '{5'd9, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
      vecs[14] = '{5'd1, 32'h0000_0000, 4'b1111, ID};

      bus.avs_gpio_address    = 5'd0;
      bus.avs_gpio_writedata  = 32'd0;
      bus.avs_gpio_byteenable = 4'd0;
      bus.avs_gpio_write      = 1'b0;
      bus.avs_gpio_read       = 1'b0;

      // Reset state
      idle(3);
      chk("rst readdata", bus.avs_gpio_readdata, 32'd0);
      chk("rst irq", irq, 1'b0);
      chk("waitrequest", bus.avs_gpio_waitrequest, 1'b0);
      rst_n = 1'b1;
      idle(1);
      rd(0, 32'd8); rd(1, ID); rd(2, 0); rd(3, 0);
      rd(4, 0); rd(5, 0); rd(6, 32'd4); rd(7, 0);

      // Register table: write then read back
      foreach (vecs[i]) begin
         wr(vecs[i].addr, vecs[i].wd, vecs[i].be);
         rd(vecs[i].addr, vecs[i].exp);
      end

      // Glitch shorter than the debounce time is ignored
      wr(5, 32'h0000_0001, 4'b0011);
      wr(4, 32'h0000_0001, 4'b0001);
      pins[0] = 1'b1;
      idle(10);
      pins[0] = 1'b0;
      hi = 0;
      repeat (40) begin
         @(negedge clk);
         if (irq) hi++;
      end
      chk("pulse irq cycles", hi, 0);
      rd(3, 0); rd(2, 0);

      // Held rise: commit after 4 ticks, irq one cycle after EDGE
      pins[0] = 1'b1;
      wait_irq(cyc, 60, lat);
      chk_rng("rise latency", lat, 16, 21);
      rd(3, 32'h01); rd(2, 32'h01);

      // W1C in the same cycle a new rise commits: set wins
      pins[0] = 1'b0;
      idle(30);
      rd(2, 0);
      chk("irq held", irq, 1'b1);
      pins[0] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (dut.g_pin[0].u_db.rise) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("rise commit seen", found, 1'b1);
      wr(3, 32'h01, 4'b0001);
      idle(1);
      chk("irq after w1c race", irq, 1'b1);
      rd(3, 32'h01);

      // Falling edge on P7, masked then unmasked, then cleared
      wr(5, 32'h0000_8001, 4'b0011);
      wr(4, 32'h0, 4'b0001);
      wr(3, 32'hFF, 4'b0001);
      idle(2);
      chk("irq cleared", irq, 1'b0);
      pins[7] = 1'b1;
      idle(30);
      rd(3, 0);
      pins[7] = 1'b0;
      idle(30);
      rd(3, 32'h80);
      chk("irq masked", irq, 1'b0);
      wr(4, 32'h80, 4'b0001);
      chk("irq mask latency", irq, 1'b0);
      idle(1);
      chk("irq unmasked", irq, 1'b1);
      wr(3, 32'h80, 4'b0001);
      idle(1);
      chk("irq after w1c", irq, 1'b0);
      rd(3, 0);

      // Enable changes do not create edges
      wr(5, 32'h0000_FFFF, 4'b0011);
      idle(2);
      rd(3, 0);
      chk("irq en change", irq, 1'b0);

      // DB_THRESH=0 bypass: stable follows sync directly
      wr(5, 32'h0000_0002, 4'b0011);
      wr(4, 32'h02, 4'b0001);
      wr(6, 32'h00, 4'b0001);
      pins[1] = 1'b1;
      idle(4);
      chk("bypass irq", irq, 1'b1);
      rd(2, 32'h03);
      wr(6, 32'h04, 4'b0001);

      // Reset mid-count with P3 high discards the count
      pins[3] = 1'b1;
      idle(8);
      rst_n = 1'b0;
      idle(2);
      chk("mid rst readdata", bus.avs_gpio_readdata, 32'd0);
      chk("mid rst irq", irq, 1'b0);
      rst_n = 1'b1;
      rel = cyc;
      rd(2, 0); rd(3, 0); rd(4, 0); rd(5, 0); rd(6, 32'd4);
      wr(5, 32'h0000_0008, 4'b0011);
      wr(4, 32'h08, 4'b0001);
      wait_irq(rel, 60, lat);
      chk_rng("post-reset rise latency", lat, 16, 19);
      rd(3, 32'h08); rd(2, 32'h0B); rd(1, ID); rd(0, 32'd8);

      idle(3);
      chk("rd queue drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
